// File: rtl/load_sequencer.sv
// Operator-driven sequencer for the operand/opcode MUX: loads A, B and opcode
// from the switch bus on button presses, runs the UC with a timeout, writes back.
//
// state   | code | meaning
// IDLE    |  0   | waiting for first press
// LOAD_A  |  1   | press captures switches into A
// LOAD_B  |  2   | press captures switches into B
// LOAD_OP |  3   | press captures switches into opcode
// EXEC    |  4   | one-cycle UC start
// WAIT    |  5   | waiting for aluDone, bounded by TIMEOUT
// WB      |  6   | one-cycle write-back of tempRegA into A
// SHOW    |  7   | result displayed, press starts the next operation
module load_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4,
    parameter bit CHAIN   = 1'b1
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       enter,
    input  logic       abort,
    input  logic       aluDone,
    output logic [1:0] seletor,
    output logic       enable,
    output logic       start,
    output logic       flagUC,
    output logic       busy,
    output logic       timeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        LOAD_OP = 3'd3,
        EXEC    = 3'd4,
        WAIT    = 3'd5,
        WB      = 3'd6,
        SHOW    = 3'd7
    } state_t;

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    state_t        st;
    logic          s1, s2, prev;
    logic          press;
    logic          chain_ok;
    logic [TW-1:0] count;

    // two-flop synchronizer plus edge detect: one press per rising edge of enter
    assign press = s2 & ~prev;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            prev     <= 1'b0;
            st       <= IDLE;
            count    <= '0;
            timeout  <= 1'b0;
            chain_ok <= 1'b0;
        end else begin
            s1   <= enter;
            s2   <= s1;
            prev <= s2;
            if (abort) begin
                st    <= IDLE;
                count <= '0;
            end else begin
                case (st)
                    IDLE: if (press) begin
                        st      <= LOAD_A;
                        timeout <= 1'b0;
                    end
                    LOAD_A:  if (press) st <= LOAD_B;
                    LOAD_B:  if (press) st <= LOAD_OP;
                    LOAD_OP: if (press) st <= EXEC;
                    EXEC: begin
                        st    <= WAIT;
                        count <= '0;
                    end
                    WAIT: begin
                        if (aluDone) begin
                            st    <= WB;
                            count <= '0;
                        end else if (count == LAST) begin
                            st       <= IDLE;
                            count    <= '0;
                            timeout  <= 1'b1;
                            chain_ok <= 1'b0;
                        end else begin
                            count <= count + TW'(1);
                        end
                    end
                    WB: begin
                        st       <= SHOW;
                        chain_ok <= 1'b1;
                    end
                    SHOW: if (press) st <= (CHAIN && chain_ok) ? LOAD_B : LOAD_A;
                    default: st <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        seletor = 2'd3;
        case (st)
            LOAD_A:  seletor = 2'd0;
            LOAD_B:  seletor = 2'd1;
            LOAD_OP: seletor = 2'd2;
            EXEC:    seletor = 2'd2;
            WB:      seletor = 2'd0;
            default: seletor = 2'd3;
        endcase
    end

    // MUX write happens on the same edge that advances the load state
    assign enable = press & ~abort & ((st == LOAD_A) | (st == LOAD_B) | (st == LOAD_OP));
    assign start  = (st == EXEC);
    assign flagUC = (st == WB);
    assign busy   = (st == EXEC) | (st == WAIT) | (st == WB);
    assign state  = st;

endmodule

// File: tb/tb_load_sequencer.sv
// Randomized and directed bench for load_sequencer; two instances (CHAIN=1 and
// CHAIN=0) are checked every cycle against a behavioural model of the sequence.
module tb_load_sequencer;

    localparam int TOUT = 15;

    logic       clock   = 1'b0;
    logic       resetN  = 1'b0;
    logic       enter   = 1'b0;
    logic       abort   = 1'b0;
    logic       aluDone = 1'b0;
    logic [1:0] sel  [2];
    logic       en   [2];
    logic       stp  [2];
    logic       fl   [2];
    logic       bz   [2];
    logic       to   [2];
    logic [2:0] stt  [2];

    always #5 clock = ~clock;

    load_sequencer #(.TIMEOUT(TOUT), .TW(4), .CHAIN(1'b1)) dut_chain (
        .clock(clock), .resetN(resetN), .enter(enter), .abort(abort), .aluDone(aluDone),
        .seletor(sel[0]), .enable(en[0]), .start(stp[0]), .flagUC(fl[0]),
        .busy(bz[0]), .timeout(to[0]), .state(stt[0])
    );

    load_sequencer #(.TIMEOUT(TOUT), .TW(4), .CHAIN(1'b0)) dut_nochain (
        .clock(clock), .resetN(resetN), .enter(enter), .abort(abort), .aluDone(aluDone),
        .seletor(sel[1]), .enable(en[1]), .start(stp[1]), .flagUC(fl[1]),
        .busy(bz[1]), .timeout(to[1]), .state(stt[1])
    );

    // reference model: operation phase, cycles spent waiting, sticky flags
    int m_st   [2];
    int m_wait [2];
    bit m_to   [2];
    bit m_ch   [2];
    bit m_pipe [3];
    bit chain_p [2] = '{1'b1, 1'b0};
    int sel_tab [8] = '{3, 0, 1, 2, 2, 3, 0, 3};

    int n_checks = 0;
    int n_fail   = 0;
    int n_en    [2];
    int n_start [2];
    int n_flag  [2];
    int sel_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_wait[i] = 0; m_to[i] = 0; m_ch[i] = 0;
        end
        for (int k = 0; k < 3; k++) m_pipe[k] = 0;
    endtask

    function automatic bit m_press();
        return m_pipe[1] && !m_pipe[2];
    endfunction

    task automatic model_edge();
        bit p;
        p = m_press();
        for (int i = 0; i < 2; i++) begin
            if (abort) begin
                m_st[i] = 0; m_wait[i] = 0;
            end else begin
                case (m_st[i])
                    0: if (p) begin m_st[i] = 1; m_to[i] = 0; end
                    1, 2, 3: if (p) m_st[i] = m_st[i] + 1;
                    4: begin m_st[i] = 5; m_wait[i] = 0; end
                    5: begin
                        m_wait[i] = m_wait[i] + 1;
                        if (aluDone) begin
                            m_st[i] = 6; m_wait[i] = 0;
                        end else if (m_wait[i] >= TOUT) begin
                            m_st[i] = 0; m_wait[i] = 0; m_to[i] = 1; m_ch[i] = 0;
                        end
                    end
                    6: begin m_st[i] = 7; m_ch[i] = 1; end
                    7: if (p) m_st[i] = (chain_p[i] && m_ch[i]) ? 2 : 1;
                    default: ;
                endcase
            end
        end
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = enter;
    endtask

    task automatic check_all();
        bit e_en;
        for (int i = 0; i < 2; i++) begin
            e_en = m_press() && (m_st[i] >= 1 && m_st[i] <= 3) && !abort;
            check($sformatf("state[%0d]", i), 32'(stt[i]), 32'(m_st[i]));
            check($sformatf("seletor[%0d]", i), 32'(sel[i]), 32'(sel_tab[m_st[i]]));
            check($sformatf("enable[%0d]", i), 32'(en[i]), 32'(e_en));
            check($sformatf("start[%0d]", i), 32'(stp[i]), 32'(m_st[i] == 4));
            check($sformatf("flagUC[%0d]", i), 32'(fl[i]), 32'(m_st[i] == 6));
            check($sformatf("busy[%0d]", i), 32'(bz[i]), 32'(m_st[i] >= 4 && m_st[i] <= 6));
            check($sformatf("timeout[%0d]", i), 32'(to[i]), 32'(m_to[i]));
            n_en[i]    += int'(en[i] === 1'b1);
            n_start[i] += int'(stp[i] === 1'b1);
            n_flag[i]  += int'(fl[i] === 1'b1);
        end
        if (en[0] === 1'b1) sel_log.push_back(int'(sel[0]));
    endtask

    // inputs change just after the falling edge; outputs sampled 1 ns later
    task automatic step(input logic e, input logic a, input logic d);
        enter = e; abort = a; aluDone = d;
        #1;
        check_all();
        @(posedge clock);
        if (resetN) model_edge();
        @(negedge clock);
    endtask

    task automatic press();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
    endtask

    int snap_en0, snap_en1, snap_fl0;
    logic e_rand;

    initial begin
        model_reset();
        for (int i = 0; i < 2; i++) begin n_en[i] = 0; n_start[i] = 0; n_flag[i] = 0; end
        repeat (3) @(negedge clock);
        #1;
        check("rst_state", 32'(stt[0]), 32'd0);
        check("rst_seletor", 32'(sel[0]), 32'd3);
        check("rst_outputs", {28'd0, en[0], stp[0], fl[0], bz[0]}, 32'd0);
        check_all();
        @(negedge clock);
        resetN = 1'b1;
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // load A, B, opcode; UC completes three cycles after start
        press();
        check("idle_to_load_a", 32'(stt[0]), 32'd1);
        sel_log.delete();
        snap_en0 = n_en[0];
        press(); press(); press();
        check("three_enables", 32'(n_en[0] - snap_en0), 32'd3);
        if (sel_log.size() == 3) begin
            check("en_sel0", 32'(sel_log[0]), 32'd0);
            check("en_sel1", 32'(sel_log[1]), 32'd1);
            check("en_sel2", 32'(sel_log[2]), 32'd2);
        end else begin
            check("en_sel_count", 32'(sel_log.size()), 32'd3);
        end
        check("start_once", 32'(n_start[0]), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        check("flag_once", 32'(n_flag[0]), 32'd1);
        check("show_state", 32'(stt[0]), 32'd7);
        check("show_busy", 32'(bz[0]), 32'd0);

        // chained press skips LOAD_A only when CHAIN is set
        snap_en0 = n_en[0];
        snap_en1 = n_en[1];
        press();
        check("chain_state", 32'(stt[0]), 32'd2);
        check("nochain_state", 32'(stt[1]), 32'd1);
        check("chain_no_enable", 32'(n_en[0] - snap_en0), 32'd0);
        check("nochain_no_enable", 32'(n_en[1] - snap_en1), 32'd0);
        step(1'b0, 1'b1, 1'b0);

        // timeout after TOUT cycles in WAIT, then cleared by the next press
        repeat (4) press();
        snap_fl0 = n_flag[0];
        repeat (20) step(1'b0, 1'b0, 1'b0);
        check("timeout_set", 32'(to[0]), 32'd1);
        check("timeout_idle", 32'(stt[0]), 32'd0);
        check("timeout_no_flag", 32'(n_flag[0] - snap_fl0), 32'd0);
        press();
        check("timeout_cleared", 32'(to[0]), 32'd0);
        check("timeout_to_load_a", 32'(stt[0]), 32'd1);

        // holding enter produces a single press
        snap_en0 = n_en[0];
        repeat (50) step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("hold_one_enable", 32'(n_en[0] - snap_en0), 32'd1);
        check("hold_state", 32'(stt[0]), 32'd2);

        // button bounce during WAIT is ignored
        press(); press();
        for (int k = 0; k < 8; k++) step(k[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        check("bounce_wait", 32'(stt[0]), 32'd5);
        step(1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // abort beats press in LOAD_B
        press();
        check("pre_abort_load_b", 32'(stt[0]), 32'd2);
        snap_en0 = n_en[0];
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("abort_no_enable", 32'(n_en[0] - snap_en0), 32'd0);
        check("abort_idle", 32'(stt[0]), 32'd0);

        // asynchronous reset in the middle of WAIT
        repeat (4) press();
        step(1'b0, 1'b0, 1'b0);
        check("pre_reset_wait", 32'(stt[0]), 32'd5);
        #3 resetN = 1'b0;
        #1;
        check("async_rst_state0", 32'(stt[0]), 32'd0);
        check("async_rst_state1", 32'(stt[1]), 32'd0);
        check("async_rst_pulses", {30'd0, stp[0], fl[0]}, 32'd0);
        model_reset();
        repeat (2) step(1'b0, 1'b0, 1'b1);
        resetN = 1'b1;
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // randomized traffic
        e_rand = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) e_rand = ~e_rand;
            step(e_rand, ($urandom_range(0, 59) == 0), ($urandom_range(0, 11) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
